dmem_responder: RTL

Data-memory responder at the far end of the MEM-stage control interface. It consumes the registered mem_read/mem_write controls plus address, store data and access size from the EX/MEM register. It services each access over a configurable number of wait cycles, stalling the pipeline until the access completes. It returns load data with sign or zero extension and a one-cycle valid pulse.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_lane_align.sv | 72 +++++++
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   size_e     - access size encoding as presented on size_in
//   state_e    - responder FSM states
//   LaneMask*  - byte-enable patterns for an access starting at lane 0
//   is_misaligned() - natural-alignment check for a size / low address pair
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11   // behaves as a word access
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam logic [3:0] LaneMaskByte = 4'b0001;
    localparam logic [3:0] LaneMaskHalf = 4'b0011;
    localparam logic [3:0] LaneMaskWord = 4'b1111;

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one 32-bit word.
// Ports:
//   addr_lo_i     - byte address bits [1:0]
//   size_i        - access size (00 byte, 01 half, 1x word)
//   is_unsigned_i - zero-extend (1) or sign-extend (0) sub-word loads
//   wdata_i       - right-justified store data
//   old_word_i    - current contents of the addressed word
//   store_word_o  - old word with the selected lanes replaced by store data
//   load_data_o   - selected lanes, right-justified and extended
//   byte_en_o     - lanes touched by the access
//   misaligned_o  - access is not naturally aligned
// Lane selection always uses the alignment-masked address; the caller decides
// whether a misaligned access is suppressed or simply masked.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] old_word_i,
    output logic [31:0] store_word_o,
    output logic [31:0] load_data_o,
    output logic [3:0]  byte_en_o,
    output logic        misaligned_o
);

    size_e       sz;
    logic [1:0]  lane;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;

    assign sz = size_e'(size_i);

    always_comb begin
        misaligned_o = is_misaligned(sz, addr_lo_i);
        lane         = 2'b00;
        byte_en_o    = LaneMaskWord;
        wdata_rep    = wdata_i;
        case (sz)
            SZ_BYTE: begin
                lane      = addr_lo_i;
                byte_en_o = LaneMaskByte << lane;
                wdata_rep = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                lane      = {addr_lo_i[1], 1'b0};
                byte_en_o = LaneMaskHalf << lane;
                wdata_rep = {2{wdata_i[15:0]}};
            end
            default: begin
                lane      = 2'b00;
                byte_en_o = LaneMaskWord;
                wdata_rep = wdata_i;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            store_word_o[8*i +: 8] = byte_en_o[i] ? wdata_rep[8*i +: 8] : old_word_i[8*i +: 8];
        end

        shifted = old_word_i >> {lane, 3'b000};
        case (sz)
            SZ_BYTE: load_data_o = is_unsigned_i ? {24'b0, shifted[7:0]}
                                                 : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data_o = is_unsigned_i ? {16'b0, shifted[15:0]}
                                                 : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with a fixed per-access wait time.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   mem_read_in  - load request;  mem_write_in - store request (wins if both)
//   addr_in      - byte address (bits above the storage range ignored)
//   wdata_in     - right-justified store data
//   size_in      - 00 byte, 01 half, 10/11 word
//   unsigned_in  - zero-extend sub-word loads when set
//   rdata_out    - load data registered on completion (0 for stores)
//   rvalid_out   - one-cycle completion pulse
//   stall_out    - hold upstream pipeline registers
//   err_out      - misaligned access trapped (only with DMEM_MISALIGN_TRAP_EN)
// Build option: define DMEM_MISALIGN_TRAP_EN to suppress misaligned accesses
// and flag them on err_out; otherwise misaligned addresses are masked.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] rdata_out,
    output logic        rvalid_out,
    output logic        stall_out,
    output logic        err_out
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic [IdxW+1:0]   addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              write_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              req;
    logic              accept;
    logic              fire;
    logic              trap;
    logic              do_write;
    logic [31:0]       old_word;
    logic [31:0]       store_word;
    logic [31:0]       load_data;
    logic [3:0]        byte_en;
    logic              misaligned;

    logic              unused_addr;
    logic              unused_byte_en;
    assign unused_addr    = ^addr_in[31:IdxW+2];
    assign unused_byte_en = ^byte_en;

    assign req    = mem_read_in | mem_write_in;
    assign accept = (state_q == StIdle) && req;
    // Last wait cycle: the access itself happens on this edge.
    assign fire   = (state_q == StWait) && (cnt_q == '0);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign trap = 1'b0;
`endif

    // Gating with reset drops a store whose final wait cycle coincides with reset.
    assign do_write = fire && write_q && !trap && !reset;
    assign old_word = mem[addr_q[IdxW+1:2]];

    dmem_lane_align u_lane_align (
        .addr_lo_i     (addr_q[1:0]),
        .size_i        (size_q),
        .is_unsigned_i (uns_q),
        .wdata_i       (wdata_q),
        .old_word_i    (old_word),
        .store_word_o  (store_word),
        .load_data_o   (load_data),
        .byte_en_o     (byte_en),
        .misaligned_o  (misaligned)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req) state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        stall_out  = 1'b0;
        rvalid_out = 1'b0;
        err_out    = 1'b0;
        if (!reset) begin
            stall_out  = accept || (state_q == StWait);
            rvalid_out = (state_q == StDone);
            err_out    = (state_q == StDone) && err_q;
        end
    end

    assign rdata_out = rdata_q;

    // Request capture, wait counter and completion registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q   <= CntW'(LATENCY - 1);
                addr_q  <= addr_in[IdxW+1:0];
                wdata_q <= wdata_in;
                size_q  <= size_in;
                uns_q   <= unsigned_in;
                write_q <= mem_write_in;
            end else if ((state_q == StWait) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end

            // err_q is set only for the cycle following fire, i.e. DONE.
            err_q <= fire && trap;
            if (fire) begin
                rdata_q <= (write_q || trap) ? 32'h0 : load_data;
            end
        end
    end

    // Storage: never reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[addr_q[IdxW+1:2]] <= store_word;
        end
    end

endmodule
